// File: rtl/instr_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : instr_sequencer
//  Purpose  : Multi-cycle fetch/decode/execute/write-back control stage that
//             drives a register file, operand muxes and an 8-bit ALU.
//             Owns the PC, branch/jump resolution, halt and retire counting.
//  Revision : 1.0  initial release
// ============================================================================
module instr_sequencer #(
   parameter int          PC_W     = 8,
   parameter logic [2:0]  BR_ALUOP = 3'b101,
   parameter int          CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   output logic             imem_req,
   input  logic             imem_ack,
   output logic [PC_W-1:0]  imem_addr,
   input  logic [15:0]      imem_data,
   output logic [1:0]       rd0_addr,
   output logic [1:0]       rd1_addr,
   output logic [1:0]       wr_addr,
   output logic             wr_en,
   output logic [8:0]       wr_data,
   output logic             alu_src1,
   output logic             alu_src2,
   output logic [2:0]       alu_op,
   output logic [7:0]       instr_i,
   input  logic [7:0]       alu_f,
   input  logic             alu_ovf,
   input  logic             alu_take_branch,
   output logic             halted,
   output logic             ovf_sticky,
   output logic [CNT_W-1:0] retired
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   logic [2:0]       state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [15:0]      ir_q, ir_d;
   logic [8:0]       result_q, result_d;
   logic             br_q, br_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic             dec_write;
   logic             dec_br;
   logic             dec_jmp;
   logic             dec_halt;
   logic [PC_W-1:0]  br_off;

   // State register: all sequencer flops, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         ir_q      <= '0;
         result_q  <= '0;
         br_q      <= 1'b0;
         sticky_q  <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         result_q  <= result_d;
         br_q      <= br_d;
         sticky_q  <= sticky_d;
         retired_q <= retired_d;
      end
   end

   // Decode: datapath controls are purely a function of the held instruction
   always_comb begin
      alu_op    = 3'b000;
      wr_addr   = ir_q[11:10];
      rd0_addr  = ir_q[9:8];
      rd1_addr  = ir_q[7:6];
      alu_src1  = 1'b1;
      alu_src2  = 1'b1;
      instr_i   = ir_q[7:0];
      dec_write = 1'b0;
      dec_br    = 1'b0;
      dec_jmp   = 1'b0;
      dec_halt  = 1'b0;
      if (!ir_q[15]) begin
         alu_op    = ir_q[14:12];
         dec_write = 1'b1;
      end else begin
         case (ir_q[14:12])
            3'b000: begin                // ADDI: rd0 + imm
               alu_src2  = 1'b0;
               dec_write = 1'b1;
            end
            3'b001: begin                // LI: zero + imm
               alu_src1  = 1'b0;
               alu_src2  = 1'b0;
               dec_write = 1'b1;
            end
            3'b010: begin                // BR: compare two registers in the ALU
               alu_op   = BR_ALUOP;
               rd0_addr = ir_q[11:10];
               rd1_addr = ir_q[9:8];
               dec_br   = 1'b1;
            end
            3'b011:  dec_jmp  = 1'b1;
            3'b111:  dec_halt = 1'b1;
            default: ;                   // NOP
         endcase
      end
   end

   // Next-state: sequencing, result capture, PC update and bookkeeping
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      result_d  = result_q;
      br_d      = br_q;
      sticky_d  = sticky_q;
      retired_d = retired_q;
      br_off    = PC_W'($signed(ir_q[7:0]));
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (imem_ack) begin
               ir_d    = imem_data;
               state_d = S_DECODE;
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            result_d = {alu_ovf, alu_f};
            br_d     = alu_take_branch;
            state_d  = dec_halt ? S_HALT : S_WB;
         end
         S_WB: begin
            if (dec_br && br_q)  pc_d = pc_q + br_off;
            else if (dec_jmp)    pc_d = ir_q[PC_W-1:0];
            else                 pc_d = pc_q + PC_W'(1);
            if (retired_q != {CNT_W{1'b1}}) retired_d = retired_q + CNT_W'(1);
            if (dec_write) sticky_d = sticky_q | result_q[8];
            state_d = run ? S_FETCH : S_IDLE;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: handshake, write strobe and status derived from the state
   always_comb begin
      imem_req   = (state_q == S_FETCH);
      imem_addr  = pc_q;
      wr_en      = (state_q == S_WB) && dec_write;
      wr_data    = result_q;
      halted     = (state_q == S_HALT);
      ovf_sticky = sticky_q;
      retired    = retired_q;
   end

endmodule
`default_nettype wire
